apb_slave_mem: RTL and testbench

Parameterised APB completer: the responder end of the team's APB master. Decodes APB setup/access phases, serves reads and writes from a word-addressed register file, inserts a fixed number of wait states, and signals `pslverr` for misaligned or out-of-range accesses. Sits on the peripheral side of the bridge as the reference target for master bring-up and system tests.

---
 rtl/apb_pkg.sv | 6 +
 rtl/apb_slave_regfile.sv | 22 ++
 rtl/apb_slave_mem.sv | 88 ++++++++
 tb/tb_apb_slave_mem.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB completer
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, RSVD = 2'd3} apb_slv_state_t;
endpackage

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: word storage with one write port, combinational read, async clear
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int DEPTH = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // storage update; reset wipes every word
  always_ff @(posedge pclk or posedge preset)
    if (preset) mem <= '{default: '0};
    else if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with fixed wait states backed by a word register file
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW = $clog2(DEPTH);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  apb_slv_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic err_q, err_d, wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata, prdata_d;
  logic pready_d, pslverr_d, setup, we;
  logic [ADDR_WIDTH-1:0] widx_full;
  assign widx_full = paddr >> OFF;
  assign setup = pselx && !penable;
  assign we = state_q == RESP && pselx && penable && wr_q && !err_q;
  apb_slave_regfile #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rf (
    .pclk(pclk), .preset(preset), .we(we), .widx(idx_q), .wdata(wdata_q),
    .ridx(idx_d), .rdata(rdata)
  );
  // next state; the counter is loaded so the response cycle lands exactly WAIT_CYCLES after T1
  always_comb begin
    state_d = IDLE;
    cnt_d = cnt_q;
    idx_d = idx_q;
    err_d = err_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (setup) begin
        state_d = WC == 4'd0 ? RESP : WAIT;
        cnt_d = WC;
        idx_d = widx_full[IW-1:0];
        err_d = (paddr & ADDR_WIDTH'(DATA_WIDTH / 8 - 1)) != '0 || widx_full >= ADDR_WIDTH'(DEPTH);
        wr_d = pwrite;
        wdata_d = pwdata;
      end
      WAIT: if (pselx) begin
        state_d = cnt_q <= 4'd1 ? RESP : WAIT;
        cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    pready_d = state_d == RESP;
    pslverr_d = pready_d && err_d;
    prdata_d = pready_d && !err_d && !wr_d ? rdata : '0;
  end
  // state, transfer latches and registered outputs
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      prdata <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      err_q <= err_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      prdata <= prdata_d;
      pready <= pready_d;
      pslverr <= pslverr_d;
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: random and directed APB traffic against two completers (0 and 3 wait states)
module tb_apb_slave_mem;
  logic clk = 1'b0, preset = 1'b1, run = 1'b0;
  logic psel [2], pen [2], pwr [2], rdy [2], serr [2], exp_rdy [2], exp_err [2];
  logic [31:0] addr [2], wdat [2], rdat [2], exp_dat [2];
  logic [31:0] mem_m [2][16];
  int pulses [2];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_CYCLES(0)) u0 (
    .pclk(clk), .preset(preset), .pselx(psel[0]), .penable(pen[0]), .pwrite(pwr[0]),
    .paddr(addr[0]), .pwdata(wdat[0]), .prdata(rdat[0]), .pready(rdy[0]), .pslverr(serr[0])
  );
  apb_slave_mem #(.WAIT_CYCLES(3)) u1 (
    .pclk(clk), .preset(preset), .pselx(psel[1]), .penable(pen[1]), .pwrite(pwr[1]),
    .paddr(addr[1]), .pwdata(wdat[1]), .prdata(rdat[1]), .pready(rdy[1]), .pslverr(serr[1])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic exp_zero(input int d);
    exp_rdy[d] = 1'b0;
    exp_err[d] = 1'b0;
    exp_dat[d] = '0;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mem_m[d][i] = '0;
  endtask

  // every cycle both completers must show exactly what the model expects
  always @(negedge clk) if (run) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pready%0d", d), 32'(rdy[d]), 32'(exp_rdy[d]));
      chk($sformatf("pslverr%0d", d), 32'(serr[d]), 32'(exp_err[d]));
      chk($sformatf("prdata%0d", d), rdat[d], exp_dat[d]);
      if (rdy[d]) pulses[d]++;
    end
  end

  task automatic idle(input int d, input bit viol);
    @(posedge clk); #1;
    psel[d] = viol;
    pen[d] = viol;
    exp_zero(d);
  endtask

  // one transfer; abort_k>0 drops pselx in that access cycle
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] v,
                      input int abort_k, output logic [31:0] got_d, output bit got_e);
    int w = d ? 3 : 0;
    bit err = (a % 4 != 0) || (a / 4 >= 16);
    got_d = 'x;
    got_e = 1'bx;
    @(posedge clk); #1;
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; addr[d] = a; wdat[d] = v;
    exp_zero(d);
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) begin
        psel[d] = 1'b0; pen[d] = 1'b0;
        exp_zero(d);
        return;
      end
      pen[d] = 1'b1;
      addr[d] = $urandom;
      wdat[d] = $urandom;
      exp_rdy[d] = k == w + 1;
      exp_err[d] = k == w + 1 && err;
      exp_dat[d] = k == w + 1 && !wr && !err ? mem_m[d][a / 4] : '0;
      if (k == w + 1) begin
        #2;
        got_d = rdat[d];
        got_e = serr[d];
        if (wr && !err) mem_m[d][a / 4] = v;
      end
    end
  endtask

  task automatic rand_run(input int d, input int n);
    logic [31:0] g, a;
    bit e;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'(4 * $urandom_range(0, 15)) :
          r == 7 ? 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3)) :
          32'h40 + 32'(4 * $urandom_range(0, 1000));
      xfer(d, 1'($urandom), a, $urandom,
           (d == 1 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, g, e);
      repeat ($urandom_range(0, 2)) idle(d, 1'($urandom));
    end
    idle(d, 1'b0);
  endtask

  initial begin
    logic [31:0] g;
    bit e;
    int p;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; pen[d] = 0; pwr[d] = 0; addr[d] = 0; wdat[d] = 0; pulses[d] = 0;
      exp_zero(d);
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", 32'(rdy[d]), 32'd0);
      chk("reset_prdata", rdat[d], 32'd0);
    end
    preset = 1'b0;
    run = 1'b1;
    // zero wait states
    xfer(0, 1, 32'h8, 32'hDEADBEEF, 0, g, e);
    chk("wr8_err", 32'(e), 32'd0);
    xfer(0, 0, 32'h8, 32'h0, 0, g, e);
    chk("rd8_data", g, 32'hDEADBEEF);
    chk("rd8_err", 32'(e), 32'd0);
    xfer(0, 0, 32'h40, 32'h0, 0, g, e);
    chk("rd40_err", 32'(e), 32'd1);
    chk("rd40_data", g, 32'd0);
    xfer(0, 1, 32'h2, 32'h1234, 0, g, e);
    chk("wr2_err", 32'(e), 32'd1);
    xfer(0, 0, 32'h0, 32'h0, 0, g, e);
    chk("rd0_after_misaligned", g, 32'd0);
    idle(0, 1'b1);
    p = pulses[0];
    for (int i = 0; i < 3; i++) xfer(0, 1, 32'(4 * i), 32'(i + 1), 0, g, e);
    idle(0, 1'b0);
    chk("b2b_pulses", 32'(pulses[0] - p), 32'd3);
    for (int i = 0; i < 3; i++) begin
      xfer(0, 0, 32'(4 * i), 32'h0, 0, g, e);
      chk("b2b_readback", g, 32'(i + 1));
    end
    rand_run(0, 80);
    // three wait states
    p = pulses[1];
    xfer(1, 0, 32'h4, 32'h0, 0, g, e);
    chk("w3_rd4_data", g, 32'd0);
    xfer(1, 1, 32'hC, 32'h55, 1, g, e);
    idle(1, 1'b0);
    chk("abort_pulses", 32'(pulses[1] - p), 32'd1);
    xfer(1, 0, 32'hC, 32'h0, 0, g, e);
    chk("abort_rdC", g, 32'd0);
    rand_run(1, 60);
    // async reset during a read response
    xfer(1, 1, 32'h0, 32'hA5A5A5A5, 0, g, e);
    xfer(1, 0, 32'h0, 32'h0, 0, g, e);
    chk("pre_rst_data", g, 32'hA5A5A5A5);
    preset = 1'b1;
    clear_model();
    exp_zero(1);
    #1;
    chk("async_rst_pready", 32'(rdy[1]), 32'd0);
    chk("async_rst_prdata", rdat[1], 32'd0);
    psel[1] = 0; pen[1] = 0;
    @(negedge clk); #1;
    preset = 1'b0;
    // async reset in the middle of a waited write
    xfer(1, 1, 32'h0, 32'hA5A5A5A5, 0, g, e);
    @(posedge clk); #1;
    psel[1] = 1; pen[1] = 0; pwr[1] = 1; addr[1] = 32'h0; wdat[1] = 32'h77;
    exp_zero(1);
    @(posedge clk); #1;
    pen[1] = 1;
    @(posedge clk); #2;
    preset = 1'b1;
    clear_model();
    #1;
    chk("midwait_rst_pready", 32'(rdy[1]), 32'd0);
    chk("midwait_rst_pslverr", 32'(serr[1]), 32'd0);
    psel[1] = 0; pen[1] = 0;
    @(negedge clk); #1;
    preset = 1'b0;
    xfer(1, 0, 32'h0, 32'h0, 0, g, e);
    chk("rd0_after_reset", g, 32'd0);
    idle(1, 1'b0);
    idle(0, 1'b0);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
